// File: rtl/mux_nto1_pipe_if.sv
// Handshake bundle for mux_nto1_pipe: upstream word/select offer, downstream
// registered output, flush and the sticky select-error flag.
interface mux_nto1_pipe_if #(
  parameter int Nbit = 32,
  parameter int NIN  = 4,
  parameter int SELW = 2
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [SELW-1:0]      mux_sel;
  logic [Nbit*NIN-1:0]  data_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [Nbit-1:0]      Data_out;
  logic [SELW-1:0]      sel_out;
  logic                 sel_err;

  modport master (
    output flush, in_valid, mux_sel, data_in, out_ready,
    input  in_ready, out_valid, Data_out, sel_out, sel_err
  );

  modport slave (
    input  flush, in_valid, mux_sel, data_in, out_ready,
    output in_ready, out_valid, Data_out, sel_out, sel_err
  );
endinterface

// File: rtl/mux_nto1_pipe.sv
// Parametrised N-to-1 selector with a registered output stage and a 2-entry
// skid buffer; ready toward upstream depends only on registered state.
module mux_nto1_pipe #(
  parameter int Nbit = 32,
  parameter int NIN  = 4,
  parameter int SELW = 2
) (
  input  logic           clk,
  input  logic           reset,
  mux_nto1_pipe_if.slave bus
);

  localparam logic [SELW:0] NIN_W = (SELW+1)'(NIN);

  // Out-of-range selects yield an all-zero word.
  function automatic logic [Nbit-1:0] pick_word(
    input logic [SELW-1:0]     sel,
    input logic [Nbit*NIN-1:0] din
  );
    logic [Nbit-1:0] w;
    w = '0;
    for (int k = 0; k < NIN; k++) begin
      w = (sel == SELW'(k)) ? din[k*Nbit +: Nbit] : w;
    end
    return w;
  endfunction

  logic [Nbit-1:0] o_data_q, o_data_d;
  logic [SELW-1:0] o_sel_q,  o_sel_d;
  logic            o_valid_q, o_valid_d;
  logic [Nbit-1:0] s_data_q, s_data_d;
  logic [SELW-1:0] s_sel_q,  s_sel_d;
  logic            s_valid_q, s_valid_d;
  logic            sel_err_q, sel_err_d;

  logic            accept_s;
  logic            sel_oor_s;
  logic [Nbit-1:0] new_word_s;

  assign accept_s   = bus.in_valid & ~s_valid_q;
  assign sel_oor_s  = ({1'b0, bus.mux_sel} >= NIN_W);
  assign new_word_s = pick_word(bus.mux_sel, bus.data_in);

  // Next-state for output/skid entries; flush beats any same-cycle accept.
  always_comb begin
    o_data_d  = o_data_q;
    o_sel_d   = o_sel_q;
    o_valid_d = o_valid_q;
    s_data_d  = s_data_q;
    s_sel_d   = s_sel_q;
    s_valid_d = s_valid_q;
    sel_err_d = sel_err_q;
    if (bus.flush) begin
      o_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      sel_err_d = sel_err_q | (accept_s & sel_oor_s);
      if (~o_valid_q | bus.out_ready) begin
        // An accept can never coincide with a full skid since in_ready is low.
        if (s_valid_q) begin
          o_data_d  = s_data_q;
          o_sel_d   = s_sel_q;
          o_valid_d = 1'b1;
          s_valid_d = 1'b0;
        end else if (accept_s) begin
          o_data_d  = new_word_s;
          o_sel_d   = bus.mux_sel;
          o_valid_d = 1'b1;
        end else begin
          o_valid_d = 1'b0;
        end
      end else begin
        if (accept_s) begin
          s_data_d  = new_word_s;
          s_sel_d   = bus.mux_sel;
          s_valid_d = 1'b1;
        end else begin
          s_valid_d = s_valid_q;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_data_q  <= '0;
      o_sel_q   <= '0;
      o_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_sel_q   <= '0;
      s_valid_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      o_data_q  <= o_data_d;
      o_sel_q   <= o_sel_d;
      o_valid_q <= o_valid_d;
      s_data_q  <= s_data_d;
      s_sel_q   <= s_sel_d;
      s_valid_q <= s_valid_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign bus.in_ready  = ~s_valid_q;
  assign bus.out_valid = o_valid_q;
  assign bus.Data_out  = o_data_q;
  assign bus.sel_out   = o_sel_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed checks of mux_nto1_pipe (4-input 32-bit and 3-input 8-bit builds)
// plus a seeded random handshake run against a queue model.
module tb_mux_nto1_pipe;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mux_nto1_pipe_if #(.Nbit(32), .NIN(4), .SELW(2)) ifa ();
  mux_nto1_pipe_if #(.Nbit(8),  .NIN(3), .SELW(2)) ifb ();

  mux_nto1_pipe #(.Nbit(32), .NIN(4), .SELW(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  mux_nto1_pipe #(.Nbit(8),  .NIN(3), .SELW(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_tab [4];
    logic [31:0] words [4];
    ent_t        e;
    logic        acc;
    logic        pop;
    logic        fl;
    int unsigned s;

    total = 0;
    bad   = 0;
    exp_tab = '{32'h00, 32'h11, 32'h22, 32'h33};

    reset        = 1'b1;
    ifa.flush    = 1'b0; ifa.in_valid = 1'b0; ifa.mux_sel = 2'd0;
    ifa.data_in  = '0;   ifa.out_ready = 1'b0;
    ifb.flush    = 1'b0; ifb.in_valid = 1'b0; ifb.mux_sel = 2'd0;
    ifb.data_in  = '0;   ifb.out_ready = 1'b0;
    tick(); tick();

    // Reset values
    check_eq("rst_valid", 64'(ifa.out_valid), 64'd0);
    check_eq("rst_data",  64'(ifa.Data_out),  64'd0);
    check_eq("rst_sel",   64'(ifa.sel_out),   64'd0);
    check_eq("rst_err",   64'(ifa.sel_err),   64'd0);
    reset = 1'b0;
    tick();
    check_eq("rst_ready", 64'(ifa.in_ready),  64'd1);

    // Streaming select 0..3 at full rate
    ifa.data_in   = {32'h33, 32'h22, 32'h11, 32'h00};
    ifa.out_ready = 1'b1;
    ifa.in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ifa.mux_sel = 2'(k);
      tick();
      check_eq($sformatf("str_data%0d", k), 64'(ifa.Data_out), 64'(exp_tab[k]));
      check_eq($sformatf("str_sel%0d", k),  64'(ifa.sel_out),   64'(k));
      check_eq($sformatf("str_vld%0d", k),  64'(ifa.out_valid), 64'd1);
      check_eq($sformatf("str_rdy%0d", k),  64'(ifa.in_ready),  64'd1);
    end
    ifa.in_valid = 1'b0;
    tick();
    check_eq("str_drain", 64'(ifa.out_valid), 64'd0);

    // Back-pressure: A into O, B into S, C refused, then released in order
    words = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'h0};
    ifa.out_ready = 1'b0;
    ifa.mux_sel   = 2'd1;
    ifa.in_valid  = 1'b1;
    ifa.data_in   = {32'h0, 32'h0, words[0], 32'hDEAD_0000};
    tick();
    check_eq("bp_a_data", 64'(ifa.Data_out), 64'hAAAA_0001);
    check_eq("bp_a_rdy",  64'(ifa.in_ready), 64'd1);
    ifa.data_in = {32'h0, 32'h0, words[1], 32'hDEAD_0000};
    tick();
    check_eq("bp_b_data", 64'(ifa.Data_out), 64'hAAAA_0001);
    check_eq("bp_b_rdy",  64'(ifa.in_ready), 64'd0);
    ifa.data_in = {32'h0, 32'h0, words[2], 32'hDEAD_0000};
    tick();
    check_eq("bp_c_hold", 64'(ifa.Data_out), 64'hAAAA_0001);
    check_eq("bp_c_rdy",  64'(ifa.in_ready), 64'd0);
    ifa.out_ready = 1'b1;
    tick();
    check_eq("bp_rel_b",  64'(ifa.Data_out), 64'hBBBB_0002);
    check_eq("bp_rel_rdy", 64'(ifa.in_ready), 64'd1);
    tick();
    check_eq("bp_rel_c",  64'(ifa.Data_out), 64'hCCCC_0003);
    check_eq("bp_rel_cv", 64'(ifa.out_valid), 64'd1);
    ifa.in_valid = 1'b0;
    tick();
    check_eq("bp_no_dup", 64'(ifa.out_valid), 64'd0);

    // Flush with both entries full and a word offered in the same cycle
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.mux_sel   = 2'd2;
    ifa.data_in   = {32'h0, 32'h1234_5678, 32'h0, 32'h0};
    tick(); tick();
    check_eq("fl_full", 64'(ifa.in_ready), 64'd0);
    ifa.flush   = 1'b1;
    ifa.data_in = {32'h0, 32'hF1F1_F1F1, 32'h0, 32'h0};
    tick();
    check_eq("fl_valid", 64'(ifa.out_valid), 64'd0);
    check_eq("fl_ready", 64'(ifa.in_ready),  64'd1);
    ifa.flush     = 1'b0;
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    tick();
    check_eq("fl_gone", 64'(ifa.out_valid), 64'd0);

    // Reset mid-stream while stalled
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.mux_sel   = 2'd3;
    ifa.data_in   = {32'h5555_AAAA, 32'h0, 32'h0, 32'h0};
    tick(); tick();
    reset = 1'b1;
    tick();
    check_eq("mr_valid", 64'(ifa.out_valid), 64'd0);
    check_eq("mr_data",  64'(ifa.Data_out),  64'd0);
    check_eq("mr_sel",   64'(ifa.sel_out),   64'd0);
    check_eq("mr_ready", 64'(ifa.in_ready),  64'd1);
    reset       = 1'b0;
    ifa.mux_sel = 2'd2;
    ifa.data_in = {32'h0, 32'h7777_0002, 32'h0, 32'h0};
    tick();
    check_eq("mr_first_v", 64'(ifa.out_valid), 64'd1);
    check_eq("mr_first_d", 64'(ifa.Data_out),  64'h7777_0002);
    ifa.in_valid = 1'b0;

    // Out-of-range select on the 3-input build
    ifb.data_in   = {8'h33, 8'h22, 8'h11};
    ifb.out_ready = 1'b1;
    ifb.in_valid  = 1'b1;
    ifb.mux_sel   = 2'd2;
    tick();
    check_eq("oor_in_data", 64'(ifb.Data_out), 64'h33);
    check_eq("oor_in_err",  64'(ifb.sel_err),  64'd0);
    ifb.mux_sel = 2'd3;
    tick();
    check_eq("oor_data", 64'(ifb.Data_out), 64'h0);
    check_eq("oor_sel",  64'(ifb.sel_out),  64'd3);
    check_eq("oor_err",  64'(ifb.sel_err),  64'd1);
    ifb.mux_sel = 2'd0;
    tick();
    check_eq("oor_sticky", 64'(ifb.sel_err), 64'd1);
    ifb.in_valid = 1'b0;
    ifb.flush    = 1'b1;
    tick();
    check_eq("oor_flush_err", 64'(ifb.sel_err),   64'd1);
    check_eq("oor_flush_v",   64'(ifb.out_valid), 64'd0);
    ifb.flush = 1'b0;
    reset     = 1'b1;
    tick();
    check_eq("oor_rst_err", 64'(ifb.sel_err), 64'd0);
    reset = 1'b0;
    tick();

    // Random handshake against a reference queue
    q.delete();
    for (int i = 0; i < 3000; i++) begin
      check_eq("rnd_ready", 64'(ifa.in_ready), 64'(q.size() < 2));
      check_eq("rnd_valid", 64'(ifa.out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        check_eq("rnd_data", 64'(ifa.Data_out), 64'(q[0].data));
        check_eq("rnd_sel",  64'(ifa.sel_out),  64'(q[0].sel));
      end
      ifa.in_valid  = ($urandom_range(0, 99) < 60);
      ifa.out_ready = ($urandom_range(0, 99) < 55);
      fl            = ($urandom_range(0, 63) == 0);
      ifa.flush     = fl;
      ifa.mux_sel   = 2'($urandom_range(0, 3));
      ifa.data_in   = {$urandom(), $urandom(), $urandom(), $urandom()};
      s             = 32'(ifa.mux_sel);
      e.sel         = ifa.mux_sel;
      e.data        = 32'(ifa.data_in >> (s * 32));
      acc           = ifa.in_valid && (q.size() < 2);
      pop           = ifa.out_ready && (q.size() > 0);
      tick();
      if (fl) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
    check_eq("rnd_no_err", 64'(ifa.sel_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
